// File: rtl/gap_junction_result_checker_pkg.sv
// Shared definitions for the gap-junction result checker: header fields, error bits, FSM states.
package gap_junction_result_checker_pkg;

  localparam int unsigned TYPE_MSB = 31;
  localparam int unsigned TYPE_LSB = 24;
  localparam int unsigned LEN_MSB  = 15;
  localparam int unsigned LEN_LSB  = 0;

  localparam int unsigned ERR_EARLY_LAST   = 0;
  localparam int unsigned ERR_MISSING_LAST = 1;
  localparam int unsigned ERR_BAD_LEN      = 2;
  localparam int unsigned ERR_BAD_TYPE     = 3;
  localparam int unsigned ERR_TIMEOUT      = 4;
  localparam int unsigned ERR_W            = 5;

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StDrain, StDone} state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gap_junction_result_checker_axis_ready_pattern.sv
// Rotating tready enable mask; bit 0 of the pattern gates the sink's ready each cycle.
module axis_ready_pattern #(
  parameter logic [7:0] PATTERN = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  output logic o_ready_en
);

  logic [7:0] r_pattern;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= PATTERN;
    end else begin
      r_pattern <= {r_pattern[6:0], r_pattern[7]};
    end
  end

  assign o_ready_en = r_pattern[0];

endmodule

// File: rtl/gap_junction_result_checker.sv
// AXI-Stream result sink: parses header, checks framing, sums payload, times start-to-done.
module gap_junction_result_checker
  import gap_junction_result_checker_pkg::*;
#(
  parameter logic [7:0]  EXPECTED_TYPE  = 8'h02,
  parameter logic [7:0]  READY_PATTERN  = 8'hFF,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_pulse,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_flags,
  output logic [15:0]      word_count,
  output logic [31:0]      checksum,
  output logic [31:0]      latency_cycles,
  output logic [15:0]      pkt_count
);

  state_e           r_state, w_state_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic [15:0]      r_wcnt, w_wcnt_d;
  logic [15:0]      r_exp, w_exp_d;
  logic [31:0]      r_sum, w_sum_d;
  logic [31:0]      r_lat, w_lat_d;
  logic             r_armed;
  logic [19:0]      r_idle;

  logic             r_done, r_pass;
  logic [ERR_W-1:0] r_err_flags;
  logic [15:0]      r_word_count, r_pkt_count;
  logic [31:0]      r_checksum, r_latency;

  logic             w_ready_en, w_active, w_beat, w_timeout_hit, w_close;
  logic             w_bad_type, w_bad_len;
  logic [15:0]      w_len;

  axis_ready_pattern #(
    .PATTERN(READY_PATTERN)
  ) u_ready_pattern (
    .clk       (clk),
    .reset     (reset),
    .o_ready_en(w_ready_en)
  );

  assign w_active      = (r_state == StHdr) || (r_state == StPay) || (r_state == StDrain);
  assign s_axis_tready = w_active & w_ready_en;
  assign w_beat        = s_axis_tvalid & s_axis_tready;
  assign w_len         = s_axis_tdata[LEN_MSB:LEN_LSB];
  assign w_bad_type    = s_axis_tdata[TYPE_MSB:TYPE_LSB] != EXPECTED_TYPE;
  assign w_bad_len     = (w_len == 16'd0) || (w_len[1:0] != 2'd0);

  // r_idle and r_lat hold cycles elapsed since their last restart, so a restart loads 1.
  assign w_timeout_hit = w_active && r_armed && !w_beat && !start_pulse &&
                         (r_idle + 20'd1 == TIMEOUT_CYCLES);
  assign w_lat_d       = start_pulse ? 32'd1 : (r_armed ? sat_inc32(r_lat) : r_lat);
  assign w_close       = (w_state_d == StDone);

  always_comb begin
    w_state_d = r_state;
    w_err_d   = r_err;
    w_wcnt_d  = r_wcnt;
    w_sum_d   = r_sum;
    w_exp_d   = r_exp;
    unique case (r_state)
      StIdle, StDone: begin
        w_state_d = enable ? StHdr : StIdle;
        w_err_d   = '0;
        w_wcnt_d  = '0;
        w_sum_d   = '0;
        w_exp_d   = '0;
      end
      StHdr: if (w_beat) begin
        w_exp_d                = {2'b00, w_len[15:2]};
        w_err_d[ERR_BAD_TYPE]  = w_bad_type;
        w_err_d[ERR_BAD_LEN]   = w_bad_len;
        if (s_axis_tlast) begin
          w_err_d[ERR_EARLY_LAST] = !(w_bad_type || w_bad_len);
          w_state_d               = StDone;
        end else begin
          w_state_d = w_bad_len ? StDrain : StPay;
        end
      end
      StPay: if (w_beat) begin
        w_wcnt_d = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
        w_sum_d  = r_sum + s_axis_tdata;
        if (r_wcnt + 16'd1 == r_exp) begin
          if (s_axis_tlast) begin
            w_state_d = StDone;
          end else begin
            w_err_d[ERR_MISSING_LAST] = 1'b1;
            w_state_d                 = StDrain;
          end
        end else if (s_axis_tlast) begin
          w_err_d[ERR_EARLY_LAST] = 1'b1;
          w_state_d               = StDone;
        end
      end
      StDrain: if (w_beat && s_axis_tlast) w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
    if (w_timeout_hit) begin
      w_err_d[ERR_TIMEOUT] = 1'b1;
      w_state_d            = StDone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_err        <= '0;
      r_wcnt       <= '0;
      r_sum        <= '0;
      r_exp        <= '0;
      r_lat        <= '0;
      r_armed      <= 1'b0;
      r_idle       <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_flags  <= '0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_latency    <= '0;
      r_pkt_count  <= '0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err_d;
      r_wcnt  <= w_wcnt_d;
      r_sum   <= w_sum_d;
      r_exp   <= w_exp_d;
      r_lat   <= w_lat_d;
      r_armed <= start_pulse | (r_armed & (r_state != StDone));
      if (start_pulse || w_beat) begin
        r_idle <= 20'd1;
      end else if (w_active && r_armed) begin
        r_idle <= r_idle + 20'd1;
      end
      // Held outputs are registered on entry so they are valid alongside the done pulse.
      r_done <= w_close;
      if (w_close) begin
        r_pass       <= (w_err_d == '0);
        r_err_flags  <= w_err_d;
        r_word_count <= w_wcnt_d;
        r_checksum   <= w_sum_d;
        r_latency    <= w_lat_d;
        r_pkt_count  <= r_pkt_count + 16'd1;
      end
    end
  end

  assign done           = r_done;
  assign pass           = r_pass;
  assign err_flags      = r_err_flags;
  assign word_count     = r_word_count;
  assign checksum       = r_checksum;
  assign latency_cycles = r_latency;
  assign pkt_count      = r_pkt_count;

endmodule

// File: tb/tb_gap_junction_result_checker.sv
// Randomized bench for gap_junction_result_checker against a packet-level reference model.
module tb_gap_junction_result_checker;

  localparam logic [7:0]  PAT = 8'hA5;
  localparam logic [19:0] TMO = 20'd50;

  logic        clk = 1'b0;
  logic        reset, enable, start_pulse;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        done, pass;
  logic [4:0]  err_flags;
  logic [15:0] word_count, pkt_count;
  logic [31:0] checksum, latency_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pat_bad = 0;
  int m_pkts = 0;
  logic [7:0] m_pat;

  gap_junction_result_checker #(
    .EXPECTED_TYPE (8'h02),
    .READY_PATTERN (PAT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start_pulse   (start_pulse),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .done          (done),
    .pass          (pass),
    .err_flags     (err_flags),
    .word_count    (word_count),
    .checksum      (checksum),
    .latency_cycles(latency_cycles),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready may only be high when the rotating mask allows it.
  always @(posedge clk) m_pat <= reset ? PAT : {m_pat[6:0], m_pat[7]};
  always @(negedge clk) if (s_axis_tready === 1'b1 && m_pat[0] !== 1'b1) pat_bad <= pat_bad + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".pass"}, pass, 0);
    check_eq({tag, ".err"}, err_flags, 0);
    check_eq({tag, ".wc"}, word_count, 0);
    check_eq({tag, ".sum"}, checksum, 0);
    check_eq({tag, ".lat"}, latency_cycles, 0);
    check_eq({tag, ".pkts"}, pkt_count, 0);
    check_eq({tag, ".ready"}, s_axis_tready, 0);
  endtask

  task automatic wait_done(output bit seen);
    int g = 0;
    seen = 0;
    while (g < 200 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        g++;
      end
    end
  endtask

  task automatic expect_close(input string tag, input logic [4:0] e_err, input logic [15:0] e_wc,
                              input logic [31:0] e_sum, input int t_start);
    bit seen;
    wait_done(seen);
    check_eq({tag, ".done_seen"}, seen, 1);
    if (seen) begin
      m_pkts++;
      check_eq({tag, ".err"}, err_flags, e_err);
      check_eq({tag, ".pass"}, pass, (e_err == 5'd0));
      check_eq({tag, ".wc"}, word_count, e_wc);
      check_eq({tag, ".sum"}, checksum, e_sum);
      check_eq({tag, ".lat"}, latency_cycles, cyc - t_start);
      check_eq({tag, ".pkts"}, pkt_count, m_pkts & 16'hFFFF);
      check_eq({tag, ".ready_in_done"}, s_axis_tready, 0);
      @(negedge clk);
      check_eq({tag, ".done_one_cycle"}, done, 0);
    end
  endtask

  // Drive one beat at a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic [31:0] d, input bit last, input bit gaps, output bit ok);
    int g = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    ok = (s_axis_tready === 1'b1);
    if (ok) @(negedge clk);
  endtask

  task automatic pulse_start(output int t_start);
    @(negedge clk);
    start_pulse = 1'b1;
    t_start     = cyc;
    @(negedge clk);
    start_pulse = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [31:0] hdr, input int last_pos,
                         input bit use_fixed, input logic [31:0] fval, input bit gaps);
    logic [31:0] pay[$];
    logic [4:0]  e_err;
    logic [15:0] e_wc;
    logic [31:0] e_sum;
    int          exp_n, n, t_start;
    bit          bt, bl, ok;
    for (int i = 0; i < last_pos; i++) pay.push_back(use_fixed ? fval : $urandom());
    bt    = hdr[31:24] != 8'h02;
    bl    = (hdr[15:0] == 16'd0) || (hdr[1:0] != 2'd0);
    exp_n = int'(hdr[15:0]) / 4;
    e_err = {1'b0, bt, bl, 2'b00};
    e_wc  = '0;
    e_sum = '0;
    if (last_pos == 0) begin
      e_err[0] = !(bt || bl);
    end else if (!bl) begin
      n = (last_pos < exp_n) ? last_pos : exp_n;
      for (int i = 0; i < n; i++) e_sum += pay[i];
      e_wc = 16'(n);
      if (last_pos < exp_n) e_err[0] = 1'b1;
      else if (last_pos > exp_n) e_err[1] = 1'b1;
    end
    pulse_start(t_start);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ok = 1;
    for (int i = 0; i <= last_pos && ok; i++) begin
      send_beat((i == 0) ? hdr : pay[i-1], (i == last_pos), gaps, ok);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) check_eq({tag, ".accept"}, s_axis_tready, 1);
    else expect_close(tag, e_err, e_wc, e_sum, t_start);
  endtask

  initial begin
    logic [31:0] h;
    int          e, lp, mode, t0, hi, dn;
    bit          ok;
    reset = 1'b1; enable = 1'b0; start_pulse = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst0");
    reset  = 1'b0;
    enable = 1'b1;

    run_pkt("nominal", 32'h02000360, 216, 1, 32'hC2700000, 0);
    check_eq("nominal.sum_const", checksum, 32'h0E800000);
    run_pkt("backpressure", 32'h02000360, 216, 1, 32'hC2700000, 1);
    run_pkt("early_last", 32'h02000360, 100, 1, 32'hC2700000, 1);
    run_pkt("missing_last", 32'h02000010, 6, 0, 0, 1);
    run_pkt("bad_type", 32'h03000360, 216, 1, 32'hC2700000, 1);
    check_eq("bad_type.sum_const", checksum, 32'h0E800000);
    run_pkt("bad_len", 32'h02000362, 216, 0, 0, 1);
    run_pkt("hdr_last", 32'h02000010, 0, 0, 0, 1);
    run_pkt("zero_len", 32'h02000000, 3, 0, 0, 1);

    for (int k = 0; k < 30; k++) begin
      h[31:24] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h02;
      h[23:16] = 8'($urandom());
      e        = $urandom_range(1, 24);
      h[15:0]  = 16'(e * 4);
      if ($urandom_range(0, 5) == 0) h[15:0] = h[15:0] + 16'($urandom_range(1, 3));
      mode = $urandom_range(0, 5);
      case (mode)
        0:       lp = 0;
        1:       lp = e + $urandom_range(1, 3);
        2:       lp = $urandom_range(1, e);
        default: lp = e;
      endcase
      run_pkt($sformatf("rand%0d", k), h, lp, 0, 0, 1);
    end

    pulse_start(t0);
    expect_close("timeout", 5'b10000, 16'd0, 32'd0, t0);
    check_eq("timeout.lat50", latency_cycles, 32'(TMO));

    // Reset in the middle of a payload, with enable dropped so the checker parks in IDLE.
    pulse_start(t0);
    ok = 1;
    for (int i = 0; i < 6 && ok; i++) send_beat((i == 0) ? 32'h02000360 : $urandom(), 0, 0, ok);
    s_axis_tdata  = 32'h1234_5678;
    s_axis_tvalid = 1'b1;
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midrst");
    m_pkts = 0;
    hi = 0;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) hi++;
      if (done === 1'b1) dn++;
    end
    check_eq("midrst.idle_no_ready", hi, 0);
    check_eq("midrst.no_done", dn, 0);
    s_axis_tvalid = 1'b0;
    enable        = 1'b1;
    run_pkt("post_rst", 32'h02000360, 216, 1, 32'hC2700000, 1);

    check_eq("ready_pattern", pat_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
